phase_timer: RTL and testbench

//  Upstream duration timer for the traffic-light controller FSM.
//  - Watches the one-hot phase outputs (fsm_g/fsm_y/fsm_r).
//  - On each phase entry, loads that phase's duration and counts it down on

---
 rtl/traffic_pkg.sv | 30 +++
 rtl/phase_timer_if.sv | 38 +++
 rtl/phase_dur_regs.sv | 82 ++++++++
 rtl/phase_timer.sv | 96 +++++++++
 tb/tb_phase_timer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller: phase codes, default
// durations and duration-register select codes.
package traffic_pkg;

    // One-hot phase codes as seen on {fsm_g, fsm_y, fsm_r}
    localparam logic [2:0] PH_G    = 3'b100;
    localparam logic [2:0] PH_Y    = 3'b010;
    localparam logic [2:0] PH_R    = 3'b001;
    localparam logic [2:0] PH_NONE = 3'b000;

    // Default counter width and phase durations in ticks
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_G_TIME = 30;
    localparam int DEF_Y_TIME = 3;
    localparam int DEF_R_TIME = 2;

    // Selects which duration register a configuration write targets
    typedef enum logic [1:0] {
        CFG_SEL_G    = 2'd0,
        CFG_SEL_Y    = 2'd1,
        CFG_SEL_R    = 2'd2,
        CFG_SEL_NONE = 2'd3
    } cfg_sel_e;

    // True only for one of the three legal phase codes
    function automatic logic is_one_hot(input logic [2:0] ph);
        return (ph == PH_G) || (ph == PH_Y) || (ph == PH_R);
    endfunction

endpackage

// File: rtl/phase_timer_if.sv
// Bundle between the traffic-light FSM (master) and the phase timer (slave).
// The cfg_* signals exist only when PHASE_TIMER_CFG_EN is defined.
interface phase_timer_if #(
    parameter int CNT_W = 8
);
    logic             tick_en;
    logic             fsm_g;
    logic             fsm_y;
    logic             fsm_r;
    logic             g_end;
    logic             y_end;
    logic             r_end;
    logic [CNT_W-1:0] remaining;
    logic             phase_err;
`ifdef PHASE_TIMER_CFG_EN
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_data;

    modport master (
        output tick_en, fsm_g, fsm_y, fsm_r, cfg_we, cfg_sel, cfg_data,
        input  g_end, y_end, r_end, remaining, phase_err
    );
    modport slave (
        input  tick_en, fsm_g, fsm_y, fsm_r, cfg_we, cfg_sel, cfg_data,
        output g_end, y_end, r_end, remaining, phase_err
    );
`else
    modport master (
        output tick_en, fsm_g, fsm_y, fsm_r,
        input  g_end, y_end, r_end, remaining, phase_err
    );
    modport slave (
        input  tick_en, fsm_g, fsm_y, fsm_r,
        output g_end, y_end, r_end, remaining, phase_err
    );
`endif
endinterface

// File: rtl/phase_dur_regs.sv
// Provides the duration for the current phase, clamped to at least 1 tick.
// With PHASE_TIMER_CFG_EN the durations live in writable registers,
// otherwise they are the constant parameters.
module phase_dur_regs
    import traffic_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int G_TIME = DEF_G_TIME,
    parameter int Y_TIME = DEF_Y_TIME,
    parameter int R_TIME = DEF_R_TIME
) (
`ifdef PHASE_TIMER_CFG_EN
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
`endif
    input  logic [2:0]       ph,
    output logic [CNT_W-1:0] dur
);

    logic [CNT_W-1:0] g_raw;
    logic [CNT_W-1:0] y_raw;
    logic [CNT_W-1:0] r_raw;
    logic [CNT_W-1:0] sel_raw;

`ifdef PHASE_TIMER_CFG_EN
    logic [CNT_W-1:0] g_dur_q, g_dur_d;
    logic [CNT_W-1:0] y_dur_q, y_dur_d;
    logic [CNT_W-1:0] r_dur_q, r_dur_d;

    // Apply a configuration write to the selected register; select 3 is ignored
    always_comb begin
        g_dur_d = g_dur_q;
        y_dur_d = y_dur_q;
        r_dur_d = r_dur_q;
        if (cfg_we) begin
            case (cfg_sel_e'(cfg_sel))
                CFG_SEL_G: g_dur_d = cfg_data;
                CFG_SEL_Y: y_dur_d = cfg_data;
                CFG_SEL_R: r_dur_d = cfg_data;
                default:   ;
            endcase
        end
    end

    // Duration registers; readers see the old value during the write cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            g_dur_q <= CNT_W'(G_TIME);
            y_dur_q <= CNT_W'(Y_TIME);
            r_dur_q <= CNT_W'(R_TIME);
        end else begin
            g_dur_q <= g_dur_d;
            y_dur_q <= y_dur_d;
            r_dur_q <= r_dur_d;
        end
    end

    assign g_raw = g_dur_q;
    assign y_raw = y_dur_q;
    assign r_raw = r_dur_q;
`else
    assign g_raw = CNT_W'(G_TIME);
    assign y_raw = CNT_W'(Y_TIME);
    assign r_raw = CNT_W'(R_TIME);
`endif

    // Pick the duration for the current phase and clamp zero up to one tick
    always_comb begin
        sel_raw = '0;
        case (ph)
            PH_G:    sel_raw = g_raw;
            PH_Y:    sel_raw = y_raw;
            PH_R:    sel_raw = r_raw;
            default: sel_raw = '0;
        endcase
        dur = (sel_raw == '0) ? CNT_W'(1) : sel_raw;
    end

endmodule

// File: rtl/phase_timer.sv
// Phase duration timer: detects phase entry, counts the phase duration down
// on tick_en strobes and returns a one-cycle end pulse for that phase.
// Optional feature macro: PHASE_TIMER_CFG_EN (runtime-writable durations).
module phase_timer
    import traffic_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int G_TIME = DEF_G_TIME,
    parameter int Y_TIME = DEF_Y_TIME,
    parameter int R_TIME = DEF_R_TIME
) (
    input logic         clk,
    input logic         rst,
    phase_timer_if.slave bus
);

    logic [2:0]       ph;
    logic             ph_valid;
    logic             entry;
    logic [CNT_W-1:0] dur;

    logic [2:0]       prev_phase_q, prev_phase_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;
    logic             phase_err_q, phase_err_d;
    logic [2:0]       end_q, end_d;

    assign ph       = {bus.fsm_g, bus.fsm_y, bus.fsm_r};
    assign ph_valid = is_one_hot(ph);
    assign entry    = ph_valid && (ph != prev_phase_q);

    phase_dur_regs #(
        .CNT_W  (CNT_W),
        .G_TIME (G_TIME),
        .Y_TIME (Y_TIME),
        .R_TIME (R_TIME)
    ) u_dur (
`ifdef PHASE_TIMER_CFG_EN
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (bus.cfg_we),
        .cfg_sel  (bus.cfg_sel),
        .cfg_data (bus.cfg_data),
`endif
        .ph       (ph),
        .dur      (dur)
    );

    // Next-state for the counter: illegal phase parks, entry loads, ticks count down
    always_comb begin
        prev_phase_d = ph;
        remaining_d  = remaining_q;
        done_d       = done_q;
        phase_err_d  = !ph_valid;
        end_d        = 3'b000;
        if (!ph_valid) begin
            remaining_d = '0;
            done_d      = 1'b1;
        end else if (entry) begin
            remaining_d = dur;
            done_d      = 1'b0;
        end else if (!done_q && bus.tick_en) begin
            if (remaining_q > CNT_W'(1)) begin
                remaining_d = remaining_q - CNT_W'(1);
            end else begin
                remaining_d = '0;
                done_d      = 1'b1;
                end_d       = ph;
            end
        end
    end

    // Timer state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_phase_q <= PH_NONE;
            remaining_q  <= '0;
            done_q       <= 1'b0;
            phase_err_q  <= 1'b0;
            end_q        <= 3'b000;
        end else begin
            prev_phase_q <= prev_phase_d;
            remaining_q  <= remaining_d;
            done_q       <= done_d;
            phase_err_q  <= phase_err_d;
            end_q        <= end_d;
        end
    end

    assign bus.g_end     = end_q[2];
    assign bus.y_end     = end_q[1];
    assign bus.r_end     = end_q[0];
    assign bus.remaining = remaining_q;
    assign bus.phase_err = phase_err_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed testbench for phase_timer with G=5, Y=2, R=3 ticks.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_phase_timer;
    import traffic_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    phase_timer_if #(.CNT_W(8)) bus ();

    phase_timer #(
        .CNT_W  (8),
        .G_TIME (5),
        .Y_TIME (2),
        .R_TIME (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setPh(input logic [2:0] p);
        bus.fsm_g = p[2];
        bus.fsm_y = p[1];
        bus.fsm_r = p[0];
    endtask

    function automatic logic [2:0] ends();
        return {bus.g_end, bus.y_end, bus.r_end};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic [7:0] exp_rem,
                              input logic [2:0] exp_ends, input logic exp_err);
        checkOutput({tag, "_rem"}, 32'(bus.remaining), 32'(exp_rem));
        checkOutput({tag, "_ends"}, 32'(ends()), 32'(exp_ends));
        checkOutput({tag, "_err"}, 32'(bus.phase_err), 32'(exp_err));
    endtask

    // Enter phase p, check the load, then count cycles until its end pulse
    task automatic runPhase(input logic [2:0] p, input int dur, input string tag);
        int n;
        setPh(p);
        stepCycle();
        checkOutput({tag, "_load"}, 32'(bus.remaining), 32'(dur));
        n = 0;
        while (n < 100 && ends() == 3'b000) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "_ticks"}, 32'(n), 32'(dur));
        checkOutput({tag, "_which"}, 32'(ends()), 32'(p));
        stepCycle();
        checkOutput({tag, "_clear"}, 32'(ends()), 32'(0));
    endtask

    // Wait, bounded, for any end pulse
    task automatic waitEnd(input string tag);
        int n;
        n = 0;
        while (n < 100 && ends() == 3'b000) begin
            stepCycle();
            n++;
        end
        checkOutput(tag, 32'(n < 100), 32'(1));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.tick_en = 1'b1;
        setPh(PH_NONE);
`ifdef PHASE_TIMER_CFG_EN
        bus.cfg_we   = 1'b0;
        bus.cfg_sel  = 2'd0;
        bus.cfg_data = 8'd0;
`endif
        $display("[TB] start");

        stepCycle();
        stepCycle();
        checkState("reset", 8'd0, 3'b000, 1'b0);

        // Red held after reset: 3,2,1,0 with a single r_end
        rst = 1'b0;
        setPh(PH_R);
        stepCycle();
        checkState("t1_load", 8'd3, 3'b000, 1'b0);
        stepCycle();
        checkState("t1_c2", 8'd2, 3'b000, 1'b0);
        stepCycle();
        checkState("t1_c1", 8'd1, 3'b000, 1'b0);
        stepCycle();
        checkState("t1_end", 8'd0, 3'b001, 1'b0);
        stepCycle();
        checkState("t1_hold1", 8'd0, 3'b000, 1'b0);
        stepCycle();
        checkState("t1_hold2", 8'd0, 3'b000, 1'b0);

        // Closed loop R->G->Y->R driven by the end pulses
        runPhase(PH_G, 5, "t2_g");
        runPhase(PH_Y, 2, "t2_y");
        runPhase(PH_R, 3, "t2_r");

        // Strobe every 4th cycle: remaining drops only on strobes
        setPh(PH_G);
        bus.tick_en = 1'b0;
        stepCycle();
        checkOutput("t3_load", 32'(bus.remaining), 32'(5));
        for (int i = 0; i < 20; i++) begin
            bus.tick_en = ((i % 4) == 3);
            stepCycle();
            checkOutput($sformatf("t3_rem_%0d", i), 32'(bus.remaining), 32'(5 - ((i + 1) / 4)));
            checkOutput($sformatf("t3_g_%0d", i), 32'(ends()), (i == 19) ? 32'(4) : 32'(0));
        end
        bus.tick_en = 1'b1;
        stepCycle();
        checkOutput("t3_clear", 32'(ends()), 32'(0));

        // Illegal phase mid-count, then recovery into yellow
        setPh(PH_Y);
        stepCycle();
        setPh(PH_G);
        stepCycle();
        checkOutput("t4_direct_g", 32'(bus.remaining), 32'(5));
        stepCycle();
        stepCycle();
        checkOutput("t4_mid", 32'(bus.remaining), 32'(3));
        setPh(3'b110);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkState($sformatf("t4_bad%0d", i), 8'd0, 3'b000, 1'b1);
        end
        setPh(PH_Y);
        stepCycle();
        checkState("t4_reload", 8'd2, 3'b000, 1'b0);
        stepCycle();
        checkState("t4_c1", 8'd1, 3'b000, 1'b0);
        stepCycle();
        checkState("t4_end", 8'd0, 3'b010, 1'b0);

        // Reset at remaining=3 in green, then reload after release
        setPh(PH_G);
        stepCycle();
        checkOutput("t5_load", 32'(bus.remaining), 32'(5));
        stepCycle();
        stepCycle();
        checkOutput("t5_mid", 32'(bus.remaining), 32'(3));
        rst = 1'b1;
        stepCycle();
        checkState("t5_rst", 8'd0, 3'b000, 1'b0);
        rst = 1'b0;
        stepCycle();
        checkState("t5_reload", 8'd5, 3'b000, 1'b0);

`ifdef PHASE_TIMER_CFG_EN
        // Write green=7 mid-count: current green unaffected, next green uses 7
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 2'd0;
        bus.cfg_data = 8'd7;
        stepCycle();
        bus.cfg_we = 1'b0;
        checkOutput("t6_unaltered", 32'(bus.remaining), 32'(4));
        waitEnd("t6_g5_done");
        stepCycle();
        runPhase(PH_Y, 2, "t6_y");
        runPhase(PH_G, 7, "t6_g7");

        // Green=0 lasts a single tick
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 2'd0;
        bus.cfg_data = 8'd0;
        stepCycle();
        bus.cfg_we = 1'b0;
        runPhase(PH_Y, 2, "t6_y2");
        runPhase(PH_G, 1, "t6_g1");

        // Write coinciding with yellow entry loads the old value
        setPh(PH_Y);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 2'd1;
        bus.cfg_data = 8'd9;
        stepCycle();
        bus.cfg_we = 1'b0;
        checkOutput("t6_entry_old", 32'(bus.remaining), 32'(2));
        waitEnd("t6_y_old_done");
        stepCycle();

        // Select 3 writes nothing
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 2'd3;
        bus.cfg_data = 8'd0;
        stepCycle();
        bus.cfg_we = 1'b0;
        runPhase(PH_R, 3, "t6_sel3_r");
        runPhase(PH_G, 1, "t6_g1b");
        runPhase(PH_Y, 9, "t6_y9");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
